// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with NOP bubble insertion, stall hold and
// optional saturating bubble/flush counters (enabled by defining ID_EX_PERF_CNT_EN).
module id_ex_pipe_reg #(
  parameter int          CTRL_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              br_flush_i,
  input  logic [31:0]       inst_ID_i,
  input  logic [31:0]       pc_ID_i,
  input  logic [31:0]       rs1_data_ID_i,
  input  logic [31:0]       rs2_data_ID_i,
  input  logic [31:0]       imm_ID_i,
  input  logic [CTRL_W-1:0] ctrl_ID_i,
  output logic [31:0]       inst_EX_o,
  output logic [31:0]       pc_EX_o,
  output logic [31:0]       rs1_data_EX_o,
  output logic [31:0]       rs2_data_EX_o,
  output logic [31:0]       imm_EX_o,
  output logic [CTRL_W-1:0] ctrl_EX_o,
  output logic              valid_EX_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic              bubble;
  logic [31:0]       inst_q, inst_d, pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  // A bubble keeps the ID pc for trace; everything else is the canonical NOP.
  always_comb begin
    bubble  = br_flush_i | flush_i;
    inst_d  = bubble ? NOP : inst_ID_i;
    pc_d    = pc_ID_i;
    rs1_d   = bubble ? 32'h0 : rs1_data_ID_i;
    rs2_d   = bubble ? 32'h0 : rs2_data_ID_i;
    imm_d   = bubble ? 32'h0 : imm_ID_i;
    ctrl_d  = bubble ? '0 : ctrl_ID_i;
    valid_d = ~bubble;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= NOP;
      pc_q    <= RESET_PC;
      rs1_q   <= 32'h0;
      rs2_q   <= 32'h0;
      imm_q   <= 32'h0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end
  assign inst_EX_o     = inst_q;
  assign pc_EX_o       = pc_q;
  assign rs1_data_EX_o = rs1_q;
  assign rs2_data_EX_o = rs2_q;
  assign imm_EX_o      = imm_q;
  assign ctrl_EX_o     = ctrl_q;
  assign valid_EX_o    = valid_q;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  // A simultaneous load-use and branch flush counts only as a branch flush.
  always_comb begin
    bubble_cnt_d = (en_i & ~br_flush_i & flush_i & ~&bubble_cnt_q) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
    flush_cnt_d  = (en_i & br_flush_i & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`else
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: table-driven check of id_ex_pipe_reg plus reset-in-stall and counter saturation.
module tb_id_ex_pipe_reg;
  localparam logic [31:0] RPC = 32'h0000_0080;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst, en, fl, br;
  logic [31:0] inst, pc, rs1, rs2, imm;
  logic [11:0] ctrl;
  logic [31:0] inst_o, pc_o, rs1_o, rs2_o, imm_o;
  logic [11:0] ctrl_o;
  logic        valid_o;
  logic [3:0]  bcnt_o, fcnt_o;
  int          pass = 0, total = 0;
  typedef struct packed {
    logic en, fl, br;
    logic [31:0] inst, pc, rs1, rs2, imm;
    logic [11:0] ctrl;
    logic [31:0] e_inst, e_pc, e_rs1, e_rs2, e_imm;
    logic [11:0] e_ctrl;
    logic e_valid;
    logic [3:0] e_b, e_f;
  } vec_t;
  vec_t vec [10];
  always #5 clk = ~clk;
  id_ex_pipe_reg #(.CTRL_W(12), .RESET_PC(RPC), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(fl), .br_flush_i(br),
    .inst_ID_i(inst), .pc_ID_i(pc), .rs1_data_ID_i(rs1), .rs2_data_ID_i(rs2),
    .imm_ID_i(imm), .ctrl_ID_i(ctrl),
    .inst_EX_o(inst_o), .pc_EX_o(pc_o), .rs1_data_EX_o(rs1_o), .rs2_data_EX_o(rs2_o),
    .imm_EX_o(imm_o), .ctrl_EX_o(ctrl_o), .valid_EX_o(valid_o),
    .bubble_cnt_o(bcnt_o), .flush_cnt_o(fcnt_o)
  );
  function automatic logic [3:0] perf(input logic [3:0] x);
`ifdef ID_EX_PERF_CNT_EN
    return x;
`else
    return 4'd0 & x;
`endif
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(input logic r, input logic e, input logic f, input logic b,
                       input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] c, input logic [31:0] m, input logic [11:0] k);
    @(negedge clk);
    rst = r; en = e; fl = f; br = b; inst = i; pc = p; rs1 = a; rs2 = c; imm = m; ctrl = k;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; fl = 1'b0; br = 1'b0;
    inst = 32'h0; pc = 32'h0; rs1 = 32'h0; rs2 = 32'h0; imm = 32'h0; ctrl = 12'h0;
    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h00A28293, 32'h104, 32'h11, 32'h22, 32'h0A, 12'h5A5,
               32'h00A28293, 32'h104, 32'h11, 32'h22, 32'h0A, 12'h5A5, 1'b1, 4'd0, 4'd0};
    vec[1] = '{1'b1, 1'b1, 1'b0, 32'h00B50533, 32'h108, 32'h33, 32'h34, 32'h35, 12'h0FF,
               NOP, 32'h108, 32'h0, 32'h0, 32'h0, 12'h000, 1'b0, 4'd1, 4'd0};
    vec[2] = '{1'b1, 1'b0, 1'b0, 32'h00A28293, 32'h10C, 32'h44, 32'h55, 32'h66, 12'h3C3,
               32'h00A28293, 32'h10C, 32'h44, 32'h55, 32'h66, 12'h3C3, 1'b1, 4'd1, 4'd0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h300, 32'h1, 32'h2, 32'h3, 12'hFFF,
               32'h00A28293, 32'h10C, 32'h44, 32'h55, 32'h66, 12'h3C3, 1'b1, 4'd1, 4'd0};
    vec[4] = '{1'b0, 1'b1, 1'b1, 32'h12345678, 32'h304, 32'h4, 32'h5, 32'h6, 12'hABC,
               32'h00A28293, 32'h10C, 32'h44, 32'h55, 32'h66, 12'h3C3, 1'b1, 4'd1, 4'd0};
    vec[5] = '{1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h308, 32'h7, 32'h8, 32'h9, 12'h123,
               32'h00A28293, 32'h10C, 32'h44, 32'h55, 32'h66, 12'h3C3, 1'b1, 4'd1, 4'd0};
    vec[6] = '{1'b1, 1'b1, 1'b1, 32'h00B50533, 32'h200, 32'h7, 32'h8, 32'h9, 12'h0AA,
               NOP, 32'h200, 32'h0, 32'h0, 32'h0, 12'h000, 1'b0, 4'd1, 4'd1};
    vec[7] = '{1'b1, 1'b0, 1'b1, 32'h00C000EF, 32'h204, 32'hA, 32'hB, 32'hC, 12'h555,
               NOP, 32'h204, 32'h0, 32'h0, 32'h0, 12'h000, 1'b0, 4'd1, 4'd2};
    vec[8] = '{1'b1, 1'b0, 1'b0, 32'h00C000EF, 32'h208, 32'hAA, 32'hBB, 32'hCC, 12'h801,
               32'h00C000EF, 32'h208, 32'hAA, 32'hBB, 32'hCC, 12'h801, 1'b1, 4'd1, 4'd2};
    vec[9] = '{1'b1, 1'b1, 1'b0, 32'h40B50533, 32'h20C, 32'hD, 32'hE, 32'hF, 12'h777,
               NOP, 32'h20C, 32'h0, 32'h0, 32'h0, 12'h000, 1'b0, 4'd2, 4'd2};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h444, 32'h1, 32'h2, 32'h3, 12'hFFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h444, 32'h1, 32'h2, 32'h3, 12'hFFF);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, RPC);
    check("rst_rs1", rs1_o, 32'h0);
    check("rst_rs2", rs2_o, 32'h0);
    check("rst_imm", imm_o, 32'h0);
    check("rst_ctrl", {20'h0, ctrl_o}, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_bcnt", {28'h0, bcnt_o}, 32'h0);
    check("rst_fcnt", {28'h0, fcnt_o}, 32'h0);
    for (int v = 0; v < 10; v++) begin
      drive(1'b0, vec[v].en, vec[v].fl, vec[v].br, vec[v].inst, vec[v].pc,
            vec[v].rs1, vec[v].rs2, vec[v].imm, vec[v].ctrl);
      check($sformatf("v%0d_inst", v), inst_o, vec[v].e_inst);
      check($sformatf("v%0d_pc", v), pc_o, vec[v].e_pc);
      check($sformatf("v%0d_rs1", v), rs1_o, vec[v].e_rs1);
      check($sformatf("v%0d_rs2", v), rs2_o, vec[v].e_rs2);
      check($sformatf("v%0d_imm", v), imm_o, vec[v].e_imm);
      check($sformatf("v%0d_ctrl", v), {20'h0, ctrl_o}, {20'h0, vec[v].e_ctrl});
      check($sformatf("v%0d_valid", v), {31'h0, valid_o}, {31'h0, vec[v].e_valid});
      check($sformatf("v%0d_bcnt", v), {28'h0, bcnt_o}, {28'h0, perf(vec[v].e_b)});
      check($sformatf("v%0d_fcnt", v), {28'h0, fcnt_o}, {28'h0, perf(vec[v].e_f)});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00A28293, 32'h500, 32'h1, 32'h2, 32'h3, 12'h111);
    check("pre_stall_valid", {31'h0, valid_o}, 32'h1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h00A28293, 32'h504, 32'h1, 32'h2, 32'h3, 12'h111);
    check("rstall_inst", inst_o, NOP);
    check("rstall_pc", pc_o, RPC);
    check("rstall_rs1", rs1_o, 32'h0);
    check("rstall_ctrl", {20'h0, ctrl_o}, 32'h0);
    check("rstall_valid", {31'h0, valid_o}, 32'h0);
    check("rstall_bcnt", {28'h0, bcnt_o}, 32'h0);
    check("rstall_fcnt", {28'h0, fcnt_o}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h00B50533, 32'h600 + 32'(i), 32'h9, 32'h9, 32'h9, 12'h9);
      check($sformatf("sat%0d_bcnt", i), {28'h0, bcnt_o}, {28'h0, perf(i < 15 ? 4'(i + 1) : 4'd15)});
      check($sformatf("sat%0d_fcnt", i), {28'h0, fcnt_o}, 32'h0);
      check($sformatf("sat%0d_valid", i), {31'h0, valid_o}, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00B50533, 32'h700, 32'h9, 32'h9, 32'h9, 12'h9);
    check("sat_hold_bcnt", {28'h0, bcnt_o}, {28'h0, perf(4'd15)});
    check("sat_hold_pc", pc_o, 32'h613);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
